// File: rtl/mul_station_scheduler.sv
// mul_station_scheduler
//   Allocates multiplier/divider stations to ops coming from issue and
//   arbitrates finished station results onto the common data bus.
//
//   Dispatch side (combinational): the lowest-index free station is offered.
//   It is allocated with a one-hot set_occupied pulse when dispatch_valid is
//   high and a station is free.
//
//   Writeback side: a two-state FSM (IDLE/HOLD). Ready results are picked
//   round-robin and latched into hold_index/hold_value. They are presented
//   on the bus until granted. A grant releases the station with
//   reset_occupied and can capture the next winner in the same cycle.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   dispatch_valid/ready    issue handshake
//   dispatch_station        station index being allocated
//   set_occupied            one-hot allocate pulse
//   station_occupied        per-station occupied flags
//   station_result_ready    per-station result-ready flags
//   station_result          flat results, station k at [k*SIZE +: SIZE]
//   bus_request/grant       common data bus handshake
//   bus_source/bus_value    held station index and result
//   reset_occupied          release pulse (one-hot on grant, all ones on flush)
//   flush                   mispredict flush, releases every station
//   stall_count             (MUL_SCHEDULER_STALL_COUNT_EN only) saturating
//                           count of cycles with bus_request && !bus_grant
//
// Optional feature macro: MUL_SCHEDULER_STALL_COUNT_EN
module mul_station_scheduler #(
    parameter int STATION_COUNT      = 4,
    parameter int STATION_INDEX_SIZE = 2,
    parameter int SIZE               = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dispatch_valid,
    output logic                          dispatch_ready,
    output logic [STATION_INDEX_SIZE-1:0] dispatch_station,
    output logic [STATION_COUNT-1:0]      set_occupied,
    input  logic [STATION_COUNT-1:0]      station_occupied,
    input  logic [STATION_COUNT-1:0]      station_result_ready,
    input  logic [STATION_COUNT*SIZE-1:0] station_result,
    output logic                          bus_request,
    input  logic                          bus_grant,
    output logic [STATION_INDEX_SIZE-1:0] bus_source,
    output logic [SIZE-1:0]               bus_value,
    output logic [STATION_COUNT-1:0]      reset_occupied,
    input  logic                          flush
`ifdef MUL_SCHEDULER_STALL_COUNT_EN
    ,
    output logic [15:0]                   stall_count
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                        state, state_next;
    logic [STATION_INDEX_SIZE-1:0] hold_index, hold_index_next;
    logic [SIZE-1:0]               hold_value, hold_value_next;
    logic [STATION_INDEX_SIZE-1:0] rr_pointer, rr_pointer_next;

    // ---------------- dispatch ----------------
    logic                          any_free;
    logic [STATION_INDEX_SIZE-1:0] free_index;

    // Descending scan so the last hit (lowest index) wins.
    always_comb begin
        any_free   = 1'b0;
        free_index = '0;
        for (int k = STATION_COUNT - 1; k >= 0; k--) begin
            if (!station_occupied[k]) begin
                any_free   = 1'b1;
                free_index = STATION_INDEX_SIZE'(k);
            end
        end
    end

    assign dispatch_ready   = any_free && !flush && !reset;
    assign dispatch_station = free_index;

    always_comb begin
        set_occupied = '0;
        if (dispatch_valid && dispatch_ready)
            set_occupied[free_index] = 1'b1;
    end

    // ---------------- writeback arbitration ----------------
    logic [STATION_COUNT-1:0]      candidates;
    logic                          found;
    logic [STATION_INDEX_SIZE-1:0] winner;
    logic [STATION_INDEX_SIZE-1:0] probe;
    int                            sum;

    // The held station is already on its way out, so it must not win again.
    always_comb begin
        candidates = station_result_ready & station_occupied;
        if (state == HOLD)
            candidates[hold_index] = 1'b0;
    end

    // Round-robin search from rr_pointer. The explicit wrap keeps this
    // correct for station counts that are not a power of two.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = 0;
        probe  = '0;
        for (int i = 0; i < STATION_COUNT; i++) begin
            sum = int'(rr_pointer) + i;
            if (sum >= STATION_COUNT)
                sum = sum - STATION_COUNT;
            probe = STATION_INDEX_SIZE'(sum);
            if (!found && candidates[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

    always_comb begin
        state_next      = state;
        hold_index_next = hold_index;
        hold_value_next = hold_value;
        rr_pointer_next = rr_pointer;
        reset_occupied  = '0;
        if (reset) begin
            // State is cleared by the register block; stations reset themselves.
        end else if (flush) begin
            reset_occupied = '1;
            state_next     = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state_next      = HOLD;
                        hold_index_next = winner;
                        hold_value_next = station_result[int'(winner)*SIZE +: SIZE];
                        rr_pointer_next = (int'(winner) == STATION_COUNT - 1) ?
                                          '0 : STATION_INDEX_SIZE'(int'(winner) + 1);
                    end
                end
                HOLD: begin
                    if (bus_grant) begin
                        reset_occupied[hold_index] = 1'b1;
                        if (found) begin
                            hold_index_next = winner;
                            hold_value_next = station_result[int'(winner)*SIZE +: SIZE];
                            rr_pointer_next = (int'(winner) == STATION_COUNT - 1) ?
                                              '0 : STATION_INDEX_SIZE'(int'(winner) + 1);
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hold_index <= '0;
            hold_value <= '0;
            rr_pointer <= '0;
        end else begin
            state      <= state_next;
            hold_index <= hold_index_next;
            hold_value <= hold_value_next;
            rr_pointer <= rr_pointer_next;
        end
    end

    // Bus outputs come straight from the hold registers. They are masked
    // while reset is high so a result held mid-operation never leaks out.
    assign bus_request = (state == HOLD) && !reset;
    assign bus_source  = bus_request ? hold_index : '0;
    assign bus_value   = bus_request ? hold_value : '0;

`ifdef MUL_SCHEDULER_STALL_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset || flush)
            stall_count <= '0;
        else if (bus_request && !bus_grant && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mul_station_scheduler.sv
module tb_mul_station_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [1:0]  dispatch_station;
    logic [3:0]  set_occupied;
    logic [3:0]  station_occupied;
    logic [3:0]  station_result_ready;
    logic [127:0] station_result;
    logic        bus_request;
    logic        bus_grant;
    logic [1:0]  bus_source;
    logic [31:0] bus_value;
    logic [3:0]  reset_occupied;
    logic        flush;
`ifdef MUL_SCHEDULER_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    logic [31:0] res [4];
    assign station_result = {res[3], res[2], res[1], res[0]};

    always #5 clock = ~clock;

    mul_station_scheduler #(
        .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .SIZE(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .dispatch_station(dispatch_station),
        .set_occupied(set_occupied),
        .station_occupied(station_occupied),
        .station_result_ready(station_result_ready),
        .station_result(station_result),
        .bus_request(bus_request),
        .bus_grant(bus_grant),
        .bus_source(bus_source),
        .bus_value(bus_value),
        .reset_occupied(reset_occupied),
        .flush(flush)
`ifdef MUL_SCHEDULER_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [3:0] occ;
        logic       flush;
        logic       exp_ready;
        logic [1:0] exp_station;
        logic [3:0] exp_set;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[1] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd1, 4'b0010};
        vecs[2] = '{1'b1, 4'b1011, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[3] = '{1'b1, 4'b0111, 1'b0, 1'b1, 2'd3, 4'b1000};
        vecs[4] = '{1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[5] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[6] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[7] = '{1'b1, 4'b1110, 1'b0, 1'b1, 2'd0, 4'b0001};

        reset = 1'b1; dispatch_valid = 1'b0; station_occupied = '0;
        station_result_ready = '0; bus_grant = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) res[i] = '0;
        tick; tick;

        // reset state
        dispatch_valid = 1'b1;
        #1;
        check("reset dispatch_ready", dispatch_ready, 0);
        check("reset set_occupied", set_occupied, 0);
        check("reset reset_occupied", reset_occupied, 0);
        check("reset bus_request", bus_request, 0);
        reset = 1'b0;
        dispatch_valid = 1'b0;
        tick;

        // combinational dispatch table (no results ready, FSM stays IDLE)
        for (int i = 0; i < 8; i++) begin
            dispatch_valid   = vecs[i].valid;
            station_occupied = vecs[i].occ;
            flush            = vecs[i].flush;
            #1;
            check($sformatf("vec%0d ready", i), dispatch_ready, vecs[i].exp_ready);
            if (vecs[i].exp_ready)
                check($sformatf("vec%0d station", i), dispatch_station, vecs[i].exp_station);
            check($sformatf("vec%0d set", i), set_occupied, vecs[i].exp_set);
            check($sformatf("vec%0d reset_occ", i), reset_occupied, vecs[i].flush ? 4'b1111 : 4'b0000);
        end
        flush = 1'b0; dispatch_valid = 1'b0; station_occupied = '0;
        tick;

        // sequential allocation with occupancy fed back
        dispatch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("alloc%0d set", i), set_occupied, 4'b0001 << i);
            station_occupied = station_occupied | set_occupied;
            tick;
        end
        dispatch_valid = 1'b0; station_occupied = '0;

        // stations 1 and 3 ready, grant held high
        station_occupied = 4'b1010; station_result_ready = 4'b1010;
        res[1] = 32'h11; res[3] = 32'h33; bus_grant = 1'b1;
        #1;
        check("idle bus_request", bus_request, 0);
        check("idle bus_value", bus_value, 0);
        tick;
        check("wb1 source", bus_source, 1);
        check("wb1 value", bus_value, 32'h11);
        check("wb1 reset_occ", reset_occupied, 4'b0010);
        station_occupied = 4'b1000;
        tick;
        check("wb2 source", bus_source, 3);
        check("wb2 value", bus_value, 32'h33);
        check("wb2 reset_occ", reset_occupied, 4'b1000);
        station_occupied = '0; station_result_ready = '0;
        tick;
        check("wb3 bus_request", bus_request, 0);
        check("wb3 bus_source", bus_source, 0);
        check("wb3 reset_occ", reset_occupied, 0);

        // capture station 1 to move rr_pointer to 2
        station_occupied = 4'b0010; station_result_ready = 4'b0010; res[1] = 32'h21;
        tick;
        check("rr prep source", bus_source, 1);
        station_occupied = '0; station_result_ready = '0;
        tick;
        // stations 0 and 3 ready, search from 2 -> 3 first
        station_occupied = 4'b1001; station_result_ready = 4'b1001;
        res[0] = 32'hA0; res[3] = 32'hA3;
        tick;
        check("rr first source", bus_source, 3);
        check("rr first value", bus_value, 32'hA3);
        station_occupied = 4'b0001;
        tick;
        check("rr second source", bus_source, 0);
        check("rr second value", bus_value, 32'hA0);
        check("rr second reset_occ", reset_occupied, 4'b0001);
        station_occupied = '0; station_result_ready = '0;
        tick;

        // stall: hold station 2 without grant for 5 cycles (rr=1)
        bus_grant = 1'b0;
        station_occupied = 4'b0101; station_result_ready = 4'b0101;
        res[0] = 32'hB0; res[2] = 32'h55;
        tick;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d source", i), bus_source, 2);
            check($sformatf("stall%0d value", i), bus_value, 32'h55);
            check($sformatf("stall%0d reset_occ", i), reset_occupied, 0);
            tick;
        end
`ifdef MUL_SCHEDULER_STALL_COUNT_EN
        check("stall_count", stall_count, 5);
`endif

        // flush in HOLD with a dispatch pending
        dispatch_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush reset_occ", reset_occupied, 4'b1111);
        check("flush set_occ", set_occupied, 4'b0000);
        check("flush ready", dispatch_ready, 0);
        tick;
        flush = 1'b0; dispatch_valid = 1'b0;
        station_occupied = '0; station_result_ready = '0;
        #1;
        check("post flush bus_request", bus_request, 0);
`ifdef MUL_SCHEDULER_STALL_COUNT_EN
        check("post flush stall_count", stall_count, 0);
`endif
        // rr_pointer survives flush (3): stations 0 and 3 -> 3 first
        station_occupied = 4'b1001; station_result_ready = 4'b1001;
        res[0] = 32'hC0; res[3] = 32'hC3;
        tick;
        check("flush rr source", bus_source, 3);
        bus_grant = 1'b1; station_occupied = 4'b0001;
        tick;
        check("flush rr next source", bus_source, 0);
        check("flush rr next value", bus_value, 32'hC0);

        // reset while holding station 0 (rr=1), grant and dispatch pending
        reset = 1'b1; dispatch_valid = 1'b1;
        #1;
        check("midreset bus_request", bus_request, 0);
        check("midreset reset_occ", reset_occupied, 0);
        check("midreset ready", dispatch_ready, 0);
        check("midreset set_occ", set_occupied, 0);
        tick;
        reset = 1'b0; bus_grant = 1'b0;
        station_occupied = '0; station_result_ready = '0;
        #1;
        check("after reset bus_request", bus_request, 0);
        check("after reset set_occ", set_occupied, 4'b0001);
        dispatch_valid = 1'b0;
        station_occupied = 4'b0011; station_result_ready = 4'b0011;
        res[0] = 32'hD0; res[1] = 32'hD1;
        tick;
        check("after reset rr source", bus_source, 0);
        check("after reset rr value", bus_value, 32'hD0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
